delay_sched: RTL and testbench

- Round-robin scheduler that time-shares one delay counter among NREQ requesters.
- Each requester asks for a delay of `dur` cycles. The block grants the counter to one requester at a time, counts the delay, then pulses that requester's `done`.
- Sits in front of the periodic-delay timing path. Its safety and liveness behaviour is written so the formal benches can check it directly.

---
 rtl/delay_sched.sv | 116 +++++++++++
 tb/tb_delay_sched.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/delay_sched.sv
// Round-robin scheduler sharing one delay counter among NREQ requesters.
// A grant runs for the saturated duration, then the owner gets a one-cycle done pulse.
module delay_sched #(
    parameter int NREQ  = 4,
    parameter int CBITS = 14,
    parameter int N     = 15000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CBITS-1:0] dur,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic [NREQ-1:0]       done,
    output logic [CBITS-1:0]      cnt,
    output logic                  err
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CBITS-1:0] NC = CBITS'(N);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           r_state;
    logic [NREQ-1:0]  r_gnt, r_done;
    logic [CBITS-1:0] r_cnt, r_tgt;
    logic [PW-1:0]    r_ptr, r_own;
    logic             r_busy, r_err;

    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_rot;
    logic [PW-1:0]     w_off, w_win, w_nxt;
    logic [PW:0]       w_sum;
    logic              w_found, w_viol;
    logic [CBITS-1:0]  w_dsel, w_tgt;

    // Rotate requests so bit 0 is the requester at ptr; lowest set bit wins.
    assign w_dbl = {req, req};
    assign w_rot = NREQ'(w_dbl >> r_ptr);

    always_comb begin
        w_off = '0;
        for (int k = NREQ-1; k >= 0; k--)
            if (w_rot[k]) w_off = PW'(k);
    end

    assign w_found = |w_rot;
    assign w_sum   = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_win   = (w_sum >= (PW+1)'(NREQ)) ? PW'(w_sum - (PW+1)'(NREQ)) : PW'(w_sum);
    assign w_nxt   = (w_win == PW'(NREQ-1)) ? '0 : w_win + 1'b1;
    assign w_dsel  = dur[w_win*CBITS +: CBITS];

    always_comb begin
        if (w_dsel == '0)    w_tgt = CBITS'(1);
        else if (w_dsel > NC) w_tgt = NC;
        else                 w_tgt = w_dsel;
    end

    assign w_viol = (r_cnt >= NC)
                  | ((r_gnt & (r_gnt - 1'b1)) != '0)
                  | ((r_done & (r_done - 1'b1)) != '0)
                  | ((r_done != '0) && (r_gnt != '0))
                  | (r_busy != (r_gnt != '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_done  <= '0;
            r_cnt   <= '0;
            r_tgt   <= '0;
            r_ptr   <= '0;
            r_own   <= '0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= r_err | w_viol;
            case (r_state)
                IDLE: begin
                    r_done <= '0;
                    if (w_found) begin
                        r_gnt   <= NREQ'(1) << w_win;
                        r_own   <= w_win;
                        r_cnt   <= '0;
                        r_ptr   <= w_nxt;
                        r_tgt   <= w_tgt;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (!req[r_own]) begin
                        r_gnt   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (r_cnt + CBITS'(1) == r_tgt) begin
                        r_done  <= r_gnt;
                        r_gnt   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CBITS'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt  = r_gnt;
    assign done = r_done;
    assign cnt  = r_cnt;
    assign busy = r_busy;
    assign err  = r_err;
endmodule

// File: tb/tb_delay_sched.sv
// Self-checking bench for delay_sched: vector table, scoreboard of expected
// completions, and hand-written sequences for withdrawal and async reset.
module tb_delay_sched;
    localparam int NREQ  = 4;
    localparam int CBITS = 14;
    localparam int N     = 15000;

    logic                  clk, rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*CBITS-1:0] dur;
    logic [NREQ-1:0]       gnt, done;
    logic                  busy, err;
    logic [CBITS-1:0]      cnt;

    delay_sched #(.NREQ(NREQ), .CBITS(CBITS), .N(N)) dut (
        .clk(clk), .rst(rst), .req(req), .dur(dur), .gnt(gnt),
        .busy(busy), .done(done), .cnt(cnt), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int idx; int d; int len; } vec_t;
    typedef struct { int idx; int len; } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dur(input int i, input int d);
        dur[i*CBITS +: CBITS] = CBITS'(d);
    endtask

    // Returns in the cycle where done is high.
    task automatic wait_done(input int maxc);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (done == '0 && k < maxc);
        if (done == '0) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_done: timeout after %0d cycles", maxc);
        end
    endtask

    // Completion monitor: length of each grant and its max count must match the scoreboard head.
    int glen = 0;
    int cmax = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            glen = 0;
        end else if (gnt != '0) begin
            if (glen == 0) cmax = 0;
            glen++;
            if (int'(cnt) > cmax) cmax = int'(cnt);
        end else if (done != '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", done, 0);
            end else begin
                e = sb.pop_front();
                chk("done_idx", done, 32'd1 << e.idx);
                chk("gnt_len", glen, e.len);
                chk("cnt_max", cmax, e.len - 1);
            end
            glen = 0;
        end else begin
            glen = 0;
        end
    end

    initial begin
        vec_t tbl[6];
        int   ng, k;
        logic [NREQ-1:0] pg;

        tbl[0] = '{0, 5, 5};
        tbl[1] = '{1, 1, 1};
        tbl[2] = '{2, 0, 1};
        tbl[3] = '{3, 2, 2};
        tbl[4] = '{1, 200, 200};
        tbl[5] = '{3, 15000, 15000};

        // Reset held with all requests up
        rst = 1'b0;
        req = '1;
        dur = '0;
        for (int i = 0; i < NREQ; i++) set_dur(i, 3);
        #2 rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_gnt", gnt, 0);
            chk("rst_done", done, 0);
            chk("rst_cnt", cnt, 0);
            chk("rst_err", err, 0);
            chk("rst_busy", busy, 0);
        end
        for (int i = 0; i < 6; i++) sb.push_back('{i % NREQ, 3});
        rst = 1'b0;

        // Round robin over held requests: 0,1,2,3,0,1
        ng = 0;
        pg = '0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (pg == '0 && gnt != '0) begin
                ng++;
                if (ng == 1) chk("first_grant", gnt, 1);
                if (ng == 6) req = gnt;
            end
            if (done != '0 && ng == 6) begin
                req = '0;
                break;
            end
            pg = gnt;
        end
        tick();
        chk("rr_grants", ng, 6);
        chk("rr_sb_empty", sb.size(), 0);
        chk("rr_err", err, 0);

        // Single request, cycle by cycle
        set_dur(0, 5);
        req = 4'b0001;
        sb.push_back('{0, 5});
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk("single_gnt", gnt, 1);
            chk("single_cnt", cnt, c - 1);
        end
        tick();
        chk("single_done", done, 1);
        chk("single_gnt_off", gnt, 0);
        req = '0;
        tick();
        chk("single_done_off", done, 0);

        // Vector table of isolated requests
        for (int v = 0; v < 6; v++) begin
            set_dur(tbl[v].idx, tbl[v].d);
            req = NREQ'(1) << tbl[v].idx;
            sb.push_back('{tbl[v].idx, tbl[v].len});
            wait_done(tbl[v].len + 5);
            req = '0;
            tick();
            chk("tbl_err", err, 0);
        end

        // Saturation, then a zero duration re-granted straight from the done cycle
        set_dur(2, 16383);
        req = 4'b0100;
        sb.push_back('{2, N});
        wait_done(N + 10);
        set_dur(2, 0);
        sb.push_back('{2, 1});
        wait_done(5);
        req = '0;
        tick();
        chk("sat_sb_empty", sb.size(), 0);

        // Withdrawal with another requester pending
        set_dur(1, 10);
        set_dur(3, 4);
        req = 4'b0010;
        tick();
        chk("wd_gnt1", gnt, 2);
        req = 4'b1010;
        k = 0;
        while (cnt != 2 && k < 10) begin
            tick();
            k++;
        end
        chk("wd_cnt2", cnt, 2);
        req = 4'b1000;
        tick();
        chk("wd_gnt_off", gnt, 0);
        chk("wd_cnt_off", cnt, 0);
        chk("wd_busy_off", busy, 0);
        chk("wd_no_done", done, 0);
        sb.push_back('{3, 4});
        tick();
        chk("wd_gnt3", gnt, 8);
        wait_done(10);
        req = '0;
        tick();

        // Asynchronous reset in the middle of a run
        set_dur(0, 20);
        req = 4'b0001;
        tick();
        chk("ar_gnt0", gnt, 1);
        k = 0;
        while (cnt != 7 && k < 20) begin
            tick();
            k++;
        end
        #2 rst = 1'b1;
        #1;
        chk("ar_gnt", gnt, 0);
        chk("ar_cnt", cnt, 0);
        chk("ar_busy", busy, 0);
        req = 4'b0110;
        set_dur(1, 3);
        tick();
        tick();
        chk("ar_done", done, 0);
        rst = 1'b0;
        sb.push_back('{1, 3});
        tick();
        chk("ar_first", gnt, 2);
        wait_done(10);
        req = '0;
        tick();

        chk("final_err", err, 0);
        chk("final_sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
